// File: rtl/branch_sched.sv
// Branch reservation station: oldest-ready-first issue into branch_ex.
// Optional same-cycle CDB bypass into select: BRANCH_SCHED_CDB_BYPASS_EN.
package core_pkg;
    localparam int XLEN       = 32;
    localparam int LOG2_PREGS = 6;
endpackage

module branch_sched #(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int PHYS_W = core_pkg::LOG2_PREGS,
    parameter int DEPTH  = 4,
    parameter int ROB_W  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic [7:0]              disp_op,
    input  logic [PHYS_W-1:0]       disp_dst_tag,
    input  logic [PHYS_W-1:0]       disp_src1_tag,
    input  logic                    disp_src1_rdy,
    input  logic [XLEN-1:0]         disp_src1_val,
    input  logic [XLEN-1:0]         disp_pc,
    input  logic [XLEN-1:0]         disp_imm,
    input  logic [ROB_W-1:0]        disp_rob_tag,
    input  logic                    cdb_valid,
    input  logic [PHYS_W-1:0]       cdb_tag,
    input  logic [XLEN-1:0]         cdb_value,
    input  logic                    flush,
    output logic                    issue_valid,
    output logic [7:0]              issue_op,
    output logic [PHYS_W-1:0]       issue_dst_tag,
    output logic [XLEN-1:0]         issue_src1_val,
    output logic [XLEN-1:0]         issue_pc,
    output logic [XLEN-1:0]         issue_imm,
    output logic [ROB_W-1:0]        issue_rob_tag,
    output logic [$clog2(DEPTH):0]  rs_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  rdy_q;
    logic [7:0]        op_q   [DEPTH];
    logic [PHYS_W-1:0] dst_q  [DEPTH];
    logic [PHYS_W-1:0] tag_q  [DEPTH];
    logic [XLEN-1:0]   val_q  [DEPTH];
    logic [XLEN-1:0]   pc_q   [DEPTH];
    logic [XLEN-1:0]   imm_q  [DEPTH];
    logic [ROB_W-1:0]  rob_q  [DEPTH];
    // older_q[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0]  older_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              iss_v_q;
    logic [7:0]        iss_op_q;
    logic [PHYS_W-1:0] iss_dst_q;
    logic [XLEN-1:0]   iss_val_q;
    logic [XLEN-1:0]   iss_pc_q;
    logic [XLEN-1:0]   iss_imm_q;
    logic [ROB_W-1:0]  iss_rob_q;

    logic [DEPTH-1:0]  wake;
    logic [DEPTH-1:0]  cand;
    logic [DEPTH-1:0]  win;
    logic              sel_v;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  free_idx;
    logic [XLEN-1:0]   sel_val;
    logic              disp_fire;
    logic              disp_hit;
    logic [XLEN-1:0]   disp_val;

    always_comb begin
        wake     = '0;
        cand     = '0;
        win      = '0;
        sel_v    = 1'b0;
        sel_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake[i] = valid_q[i] && !rdy_q[i] && cdb_valid
                   && (cdb_tag == tag_q[i]);
`ifdef BRANCH_SCHED_CDB_BYPASS_EN
            cand[i] = valid_q[i] && (rdy_q[i] || wake[i]);
`else
            cand[i] = valid_q[i] && rdy_q[i];
`endif
        end
        // A candidate wins only if no other candidate is older
        for (int i = 0; i < DEPTH; i++) begin
            win[i] = cand[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && cand[j] && older_q[j][i]) begin
                    win[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (win[i]) begin
                sel_v   = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef BRANCH_SCHED_CDB_BYPASS_EN
    assign sel_val = rdy_q[sel_idx] ? val_q[sel_idx] : cdb_value;
`else
    assign sel_val = val_q[sel_idx];
`endif

    assign disp_ready = (cnt_q < CNT_W'(DEPTH)) && !flush;
    assign disp_fire  = disp_valid && disp_ready;
    assign disp_hit   = cdb_valid && (cdb_tag == disp_src1_tag);
    assign disp_val   = disp_src1_rdy ? disp_src1_val : cdb_value;
    assign cnt_d      = cnt_q + CNT_W'(disp_fire) - CNT_W'(sel_v);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            rdy_q     <= '0;
            cnt_q     <= '0;
            iss_v_q   <= 1'b0;
            iss_op_q  <= '0;
            iss_dst_q <= '0;
            iss_val_q <= '0;
            iss_pc_q  <= '0;
            iss_imm_q <= '0;
            iss_rob_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            cnt_q   <= '0;
            iss_v_q <= 1'b0;
        end else begin
            iss_v_q <= sel_v;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_q | wake;
            if (sel_v) begin
                valid_q[sel_idx] <= 1'b0;
                iss_op_q  <= op_q[sel_idx];
                iss_dst_q <= dst_q[sel_idx];
                iss_val_q <= sel_val;
                iss_pc_q  <= pc_q[sel_idx];
                iss_imm_q <= imm_q[sel_idx];
                iss_rob_q <= rob_q[sel_idx];
            end
            if (disp_fire) begin
                valid_q[free_idx] <= 1'b1;
                rdy_q[free_idx]   <= disp_src1_rdy || disp_hit;
                older_q[free_idx] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != int'(free_idx)) begin
                        older_q[j][free_idx] <= 1'b1;
                    end
                end
            end
        end
    end

    // Payload is qualified by valid_q, so it needs no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wake[i]) begin
                val_q[i] <= cdb_value;
            end
        end
        if (disp_fire) begin
            op_q[free_idx]  <= disp_op;
            dst_q[free_idx] <= disp_dst_tag;
            tag_q[free_idx] <= disp_src1_tag;
            val_q[free_idx] <= disp_val;
            pc_q[free_idx]  <= disp_pc;
            imm_q[free_idx] <= disp_imm;
            rob_q[free_idx] <= disp_rob_tag;
        end
    end

    assign issue_valid    = iss_v_q;
    assign issue_op       = iss_op_q;
    assign issue_dst_tag  = iss_dst_q;
    assign issue_src1_val = iss_val_q;
    assign issue_pc       = iss_pc_q;
    assign issue_imm      = iss_imm_q;
    assign issue_rob_tag  = iss_rob_q;
    assign rs_count       = cnt_q;

endmodule
